// File: rtl/lane_unpacker_pkg.sv
// Shared types and constants for the lane unpacker.
// Holds the FSM state encoding, lane direction codes and index-width helper.
package lane_unpacker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    function automatic int idx_width(input int nlanes);
        return (nlanes > 1) ? $clog2(nlanes) : 1;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Combinational lane picker: selects one LANE_W slice of a word,
// counting lanes from the LSB (ascending) or from the MSB (descending).
module lane_select
    import lane_unpacker_pkg::*;
#(
    parameter int  DATA_W = 256,
    parameter int  LANE_W = 8,
    localparam int NLANES = DATA_W / LANE_W,
    localparam int IDX_W  = idx_width(NLANES)
) (
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    input  logic              dir,
    output logic [LANE_W-1:0] lane
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NLANES - 1);

    logic [IDX_W-1:0] phys;

    // A descending index k names the same bits as ascending lane NLANES-1-k.
    always_comb begin
        phys = (dir == DIR_DESC) ? (TOP_IDX - idx) : idx;
        lane = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (phys == IDX_W'(i)) begin
                lane = word[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/lane_unpacker.sv
// Accepts one wide word and streams a run of its lanes out, one per
// handshake, wrapping the lane index and chaining the next word bubble-free.
module lane_unpacker
    import lane_unpacker_pkg::*;
#(
    parameter int  DATA_W = 256,
    parameter int  LANE_W = 8,
    localparam int NLANES = DATA_W / LANE_W,
    localparam int IDX_W  = idx_width(NLANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic [IDX_W-1:0]  in_start,
    input  logic [IDX_W-1:0]  in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    if ((DATA_W % LANE_W) != 0 || DATA_W < LANE_W) begin : g_bad_width
        $error("lane_unpacker: DATA_W must be a multiple of LANE_W");
    end

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NLANES - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                dir_q, dir_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    rem_q, rem_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                last_q, last_d;

    logic accept;
    logic lane_hs;

    assign out_valid = (state_q == EMIT);
    assign out_data  = lane_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

    assign accept  = in_valid && in_ready;
    assign lane_hs = out_valid && out_ready;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            EMIT: in_ready = last_q && out_ready;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        if (accept) begin
            state_d = EMIT;
            word_d  = in_data;
            dir_d   = in_dir;
            idx_d   = in_start;
            rem_d   = in_count;
        end else if (lane_hs) begin
            if (last_q) begin
                state_d = IDLE;
            end else begin
                idx_d = (idx_q == TOP_IDX) ? '0 : idx_q + IDX_W'(1);
                rem_d = rem_q - IDX_W'(1);
            end
        end
        last_d = (state_d == EMIT) && (rem_d == '0);
    end

    // Lane data is looked up from next-state values so it lands in a flop.
    lane_select #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .word (word_d),
        .idx  (idx_d),
        .dir  (dir_d),
        .lane (lane_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            dir_q   <= DIR_ASC;
            idx_q   <= '0;
            rem_q   <= '0;
            lane_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_lane_unpacker.sv
// Scoreboard bench for lane_unpacker at DATA_W=32, LANE_W=8: directed
// cases plus randomized words and backpressure against a byte-level model.
module tb_lane_unpacker;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int NL = DW / LW;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_dir;
    logic [1:0]    in_start;
    logic [1:0]    in_count;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_last;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_ready = 1'b0;
    logic forced_ready = 1'b1;

    lane_unpacker #(
        .DATA_W (DW),
        .LANE_W (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_start  (in_start),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    end

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endfunction

    // Reference: the k-th emitted lane is logical lane (start+k) mod NL;
    // descending lane i is byte NL-1-i counted from the LSB.
    task automatic model_push(input logic [31:0] w, input logic d,
                              input int s, input int c);
        for (int k = 0; k <= c; k++) begin
            int   i;
            int   sh;
            exp_t e;
            i      = (s + k) % NL;
            sh     = d ? (NL - 1 - i) : i;
            e.data = 8'((w >> (8 * sh)) & 32'hFF);
            e.idx  = 2'(i);
            e.last = (k == c);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic d,
                        input int s, input int c);
        bit ok;
        ok       = 1'b0;
        in_data  = w;
        in_dir   = d;
        in_start = 2'(s);
        in_count = 2'(c);
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                model_push(w, d, s, c);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_data  = $urandom;
        in_dir   = 1'($urandom);
        in_start = 2'($urandom);
        in_count = 2'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic       stalled = 1'b0;
    logic [7:0] h_data;
    logic [1:0] h_idx;
    logic       h_last;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(h_data));
                chk("hold_idx", 32'(out_idx), 32'(h_idx));
                chk("hold_last", 32'(out_last), 32'(h_last));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_lane", 32'(out_valid), 32'd0);
                end else if (out_ready) begin
                    mon_e = exp_q.pop_front();
                    chk("lane_data", 32'(out_data), 32'(mon_e.data));
                    chk("lane_idx", 32'(out_idx), 32'(mon_e.idx));
                    chk("lane_last", 32'(out_last), 32'(mon_e.last));
                end
            end else if (exp_q.size() != 0) begin
                chk("bubble", 32'(out_valid), 32'd1);
            end
            stalled = out_valid && !out_ready;
            h_data  = out_data;
            h_idx   = out_idx;
            h_last  = out_last;
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        in_start = '0;
        in_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        send(32'hDDCCBBAA, 1'b0, 0, 3);
        drain();
        send(32'hDDCCBBAA, 1'b1, 0, 1);
        drain();
        send(32'hDDCCBBAA, 1'b0, 3, 2);
        drain();
        send(32'hDDCCBBAA, 1'b1, 2, 3);
        drain();

        send(32'h44332211, 1'b0, 0, 3);
        @(posedge clk);
        #1;
        forced_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        forced_ready = 1'b1;
        drain();

        send(32'h87654321, 1'b0, 1, 1);
        send(32'hA5B6C7D8, 1'b1, 2, 3);
        send(32'h0F1E2D3C, 1'b0, 0, 0);
        drain();

        send(32'h11223344, 1'b0, 0, 3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_out_data", 32'(out_data), 32'd0);
        chk("postrst_out_idx", 32'(out_idx), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_quiet", 32'(out_valid), 32'd0);

        rnd_ready = 1'b1;
        repeat (150) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 1'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end
        rnd_ready = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
